multimode_ping_pong_counter: RTL and testbench
==============================================

# multimode_ping_pong_counter

Parametrised, multi-mode successor to the 4-bit ping-pong counter. It counts between run-time bounds `min`/`max` with a programmable step, and supports four modes: ping-pong, saturate, wrap and hold. It also provides a synchronous load, a reversal/wrap event pulse and a saturating bounce counter. It sits in the display/stimulus datapath as a general sweep generator.

## Interface
- `WIDTH`, 4, counter/bound width (≥2)
- `STEP_W`, 2, width of `step`
- `BCNT_W`, 8, width of `bounce_cnt`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `enable`  in  1  advance counter this cycle
- `flip`  in  1  invert direction (acted on only when `enable`=1)
- `mode`  in  2  00 ping-pong, 01 saturate, 10 wrap, 11 hold
- `max`, `min`  in  WIDTH  inclusive bounds
- `step`  in  STEP_W  increment magnitude; 0 treated as 1
- `load`  in  1  synchronous load of `load_val`
- `load_val`  in  WIDTH  load value
- `out`  out  WIDTH  count
- `direction`  out  1  1 = up, 0 = down
- `done`  out  1  saturate mode reached a bound
- `event_p`  out  1  one-cycle pulse after an automatic reversal or wrap
- `bounce_cnt`  out  BCNT_W  automatic ping-pong reversals, saturating
- `err`  out  1  combinational: `max`≤`min` OR `out`<`min` OR `out`>`max`

## Operation
- **Reset:** `out`=`min` (sampled at that edge), `direction`=1, `done`=0, `event_p`=0, `bounce_cnt`=0.
- **Priority per cycle:** reset > `load` > `err`/hold > counting.
- **`load`:** ignored if `max`≤`min`. Otherwise `out` = `load_val` clamped into [`min`,`max`], `done`=0, `bounce_cnt`=0. `direction` is unchanged.
- **Freeze:** if `enable`=0, `err`=1 or `mode`=11, all registers hold. `event_p` is 0 and `flip` is ignored.
- **Arithmetic:** sums and differences are computed in WIDTH+1 bits; no overflow is possible. Let s = (`step`==0) ? 1 : `step`.
- **Ping-pong (00):**
  - nd = `flip` ? ~`direction` : (`out`==`max` ? 0 : `out`==`min` ? 1 : `direction`).
  - `out` moves by s in direction nd, clamped to the bound.
  - A reversal caused by a bound (not by `flip`) sets `event_p` and increments `bounce_cnt`, saturating at all-ones.
- **Saturate (01):**
  - `out` moves by s in `direction`, clamped.
  - When `out` reaches the bound in the current direction, `done`=1 and counting stops.
  - `flip` inverts `direction`, clears `done` and resumes counting in the same cycle.
- **Wrap (10):**
  - Up: if `out`==`max`, next = `min` and `event_p`=1; else next = min(`out`+s, `max`).
  - Down: the mirror image.
  - `flip` inverts `direction` and the step is then taken in the new direction.
- **Mode change mid-count:** takes effect on the next edge. `done` is cleared when leaving mode 01.

## Timing
- All outputs except `err` are registered. A single-cycle latency applies from any input to `out`/`direction`.
- `event_p` is high for exactly the cycle after the edge that performed the reversal/wrap.
- `bounce_cnt` updates on the same edge as `out`.
- `err` follows `max`/`min` changes combinationally, with no latency.
- Bounds changed while counting: the next edge evaluates with the new bounds. An `out` outside the new range asserts `err` and freezes the counter until `load` or reset.

## Test plan
- **Ping-pong:** WIDTH=4, `min`=2, `max`=6, `step`=1, mode 00. After reset, `out` = 2,3,4,5,6,5,4,3,2,3. `event_p` pulses after the reversals at 6 and 2; `bounce_cnt`=2.
- **Step clamp:** `min`=0, `max`=9, `step`=3, mode 00. `out` = 0,3,6,9,6,3,0,3.
- **Wrap:** mode 10, `min`=1, `max`=4, `step`=2. `out` = 1,3,4,1,3. Setting `flip` when `out`=3 gives 1, then 4.
- **Saturate:** mode 01, `min`=0, `max`=5, `step`=2. `out` = 0,2,4,5 with `done`=1 and `out` held at 5. A `flip` pulse gives `out`=3, `done`=0.
- **Priority/edge cases:**
  - `load`=1, `load_val`=15 with `max`=7: `out`=7.
  - `max`=`min`=3: `err`=1 and the counter freezes.
  - `rst_n`=0 mid-count: `out`=`min` and `bounce_cnt`=0 on the next edge.

Source files
------------

// File: rtl/multimode_ping_pong_counter.sv
// Multi-mode sweep counter: ping-pong, saturate, wrap and hold.
// It uses run-time bounds and a step, and counts bound reversals.
module multimode_ping_pong_counter #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2,
  parameter int BCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flip,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  max,
  input  logic [WIDTH-1:0]  min,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              direction,
  output logic              done,
  output logic              event_p,
  output logic [BCNT_W-1:0] bounce_cnt,
  output logic              err
);

  localparam int EW =
    ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  localparam logic [1:0] M_PP   = 2'b00;
  localparam logic [1:0] M_SAT  = 2'b01;
  localparam logic [1:0] M_WRAP = 2'b10;

  logic [EW-1:0]     s_e;
  logic [EW-1:0]     out_e;
  logic [EW-1:0]     max_e;
  logic [EW-1:0]     min_e;
  logic [EW-1:0]     up_sum;
  logic [EW-1:0]     dn_floor;
  logic [WIDTH-1:0]  up_val;
  logic [WIDTH-1:0]  dn_val;
  logic [WIDTH-1:0]  ld_val;

  logic              at_max;
  logic              at_min;
  logic              bnd_err;
  logic              load_ok;
  logic              freeze;

  logic              pp_dir;
  logic              pp_rev;
  logic              sat_dir;
  logic              sat_go;
  logic [WIDTH-1:0]  sat_out;
  logic              wr_dir;
  logic              wr_wrap;
  logic [BCNT_W-1:0] bcnt_inc;

  logic [WIDTH-1:0]  nxt_out;
  logic              nxt_dir;
  logic              nxt_done;
  logic              nxt_ev;
  logic [BCNT_W-1:0] nxt_bcnt;

  // Widened operands so step arithmetic never overflows.
  always_comb begin
    s_e      = (step == '0) ? EW'(1) : EW'(step);
    out_e    = EW'(out);
    max_e    = EW'(max);
    min_e    = EW'(min);
    up_sum   = out_e + s_e;
    dn_floor = min_e + s_e;
    up_val   = (up_sum > max_e)
             ? max : WIDTH'(up_sum);
    dn_val   = (out_e < dn_floor)
             ? min : WIDTH'(out_e - s_e);
  end

  // Bound checks, load clamp and the freeze condition.
  always_comb begin
    at_max  = (out == max);
    at_min  = (out == min);
    bnd_err = (max <= min);
    err     = bnd_err | (out < min) | (out > max);
    load_ok = load & ~bnd_err;
    freeze  = ~enable | err | (mode == 2'b11);
    if (load_val < min)      ld_val = min;
    else if (load_val > max) ld_val = max;
    else                     ld_val = load_val;
  end

  // Per-mode direction decisions.
  always_comb begin
    if (flip)        pp_dir = ~direction;
    else if (at_max) pp_dir = 1'b0;
    else if (at_min) pp_dir = 1'b1;
    else             pp_dir = direction;
    pp_rev   = ~flip & (pp_dir != direction);
    sat_dir  = flip ? ~direction : direction;
    sat_go   = flip | ~done;
    sat_out  = sat_dir ? up_val : dn_val;
    wr_dir   = flip ? ~direction : direction;
    wr_wrap  = wr_dir ? at_max : at_min;
    bcnt_inc = (&bounce_cnt)
             ? bounce_cnt
             : bounce_cnt + BCNT_W'(1);
  end

  // Next counting state selected by mode.
  always_comb begin
    nxt_out  = out;
    nxt_dir  = direction;
    nxt_done = done;
    nxt_ev   = 1'b0;
    nxt_bcnt = bounce_cnt;
    unique case (mode)
      M_PP: begin
        nxt_dir  = pp_dir;
        nxt_out  = pp_dir ? up_val : dn_val;
        nxt_done = 1'b0;
        nxt_ev   = pp_rev;
        if (pp_rev) nxt_bcnt = bcnt_inc;
      end
      M_SAT: begin
        if (sat_go) begin
          nxt_dir  = sat_dir;
          nxt_out  = sat_out;
          nxt_done = sat_dir
                   ? (sat_out == max)
                   : (sat_out == min);
        end
      end
      M_WRAP: begin
        nxt_dir  = wr_dir;
        nxt_done = 1'b0;
        nxt_ev   = wr_wrap;
        if (wr_wrap)
          nxt_out = wr_dir ? min : max;
        else
          nxt_out = wr_dir ? up_val : dn_val;
      end
      default: begin
        nxt_out = out;
      end
    endcase
  end

  // State registers: reset, then load, then freeze, then count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out        <= min;
      direction  <= 1'b1;
      done       <= 1'b0;
      event_p    <= 1'b0;
      bounce_cnt <= '0;
    end else if (load_ok) begin
      out        <= ld_val;
      done       <= 1'b0;
      event_p    <= 1'b0;
      bounce_cnt <= '0;
    end else if (freeze) begin
      event_p    <= 1'b0;
    end else begin
      out        <= nxt_out;
      direction  <= nxt_dir;
      done       <= nxt_done;
      event_p    <= nxt_ev;
      bounce_cnt <= nxt_bcnt;
    end
  end

endmodule

// File: tb/tb_multimode_ping_pong_counter.sv
// Bench for multimode_ping_pong_counter: directed sweeps
// plus random stimulus against an integer reference model.
module tb_multimode_ping_pong_counter;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 2;
  localparam int BCNT_W = 8;
  localparam int BMAX   = (1 << BCNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              flip;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  max;
  logic [WIDTH-1:0]  min;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  out;
  logic              direction;
  logic              done;
  logic              event_p;
  logic [BCNT_W-1:0] bounce_cnt;
  logic              err;

  int checks   = 0;
  int failures = 0;

  multimode_ping_pong_counter #(
    .WIDTH (WIDTH),
    .STEP_W(STEP_W),
    .BCNT_W(BCNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .flip      (flip),
    .mode      (mode),
    .max       (max),
    .min       (min),
    .step      (step),
    .load      (load),
    .load_val  (load_val),
    .out       (out),
    .direction (direction),
    .done      (done),
    .event_p   (event_p),
    .bounce_cnt(bounce_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference model: plain integers, rules applied directly.
  int m_out = 0;
  int m_b   = 0;
  bit m_dir = 1'b1;
  bit m_done = 1'b0;
  bit m_ev  = 1'b0;
  bit armed = 1'b0;

  function automatic int moved(int o, bit up, int s,
                               int lo, int hi);
    if (up) return (o + s > hi) ? hi : o + s;
    return (o - s < lo) ? lo : o - s;
  endfunction

  always @(posedge clk) begin
    int s, lo, hi, ld;
    bit e, nd;
    lo = int'(min);
    hi = int'(max);
    ld = int'(load_val);
    s  = (step == 0) ? 1 : int'(step);
    e  = (hi <= lo) || (m_out < lo) || (m_out > hi);
    if (!rst_n) begin
      armed = 1'b1;
      m_out = lo; m_dir = 1'b1; m_done = 1'b0;
      m_ev = 1'b0; m_b = 0;
    end else if (load && hi > lo) begin
      m_out = (ld < lo) ? lo : (ld > hi) ? hi : ld;
      m_done = 1'b0; m_b = 0; m_ev = 1'b0;
    end else if (!enable || e || mode == 2'd3) begin
      m_ev = 1'b0;
    end else if (mode == 2'd0) begin
      if (flip) nd = !m_dir;
      else if (m_out == hi) nd = 1'b0;
      else if (m_out == lo) nd = 1'b1;
      else nd = m_dir;
      m_ev = !flip && (nd != m_dir);
      if (m_ev && m_b < BMAX) m_b++;
      m_out = moved(m_out, nd, s, lo, hi);
      m_dir = nd;
      m_done = 1'b0;
    end else if (mode == 2'd1) begin
      m_ev = 1'b0;
      if (!m_done || flip) begin
        nd = flip ? !m_dir : m_dir;
        m_out = moved(m_out, nd, s, lo, hi);
        m_dir = nd;
        m_done = (m_out == (nd ? hi : lo));
      end
    end else begin
      nd = flip ? !m_dir : m_dir;
      m_dir = nd;
      m_done = 1'b0;
      if (nd && m_out == hi) begin
        m_out = lo; m_ev = 1'b1;
      end else if (!nd && m_out == lo) begin
        m_out = hi; m_ev = 1'b1;
      end else begin
        m_out = moved(m_out, nd, s, lo, hi);
        m_ev = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit m_err;
    if (armed) begin
      m_err = (int'(max) <= int'(min)) ||
              (m_out < int'(min)) ||
              (m_out > int'(max));
      chk("out", 32'(out), 32'(m_out));
      chk("direction", 32'(direction), 32'(m_dir));
      chk("done", 32'(done), 32'(m_done));
      chk("event_p", 32'(event_p), 32'(m_ev));
      chk("bounce_cnt", 32'(bounce_cnt), 32'(m_b));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic restart(input int lo, input int hi,
                         input int st, input int md);
    rst_n = 1'b0;
    min   = WIDTH'(lo);
    max   = WIDTH'(hi);
    step  = STEP_W'(st);
    mode  = 2'(md);
    cyc();
    chk("reset_out", 32'(out), 32'(lo));
    rst_n = 1'b1;
  endtask

  int pp_o[9]  = '{3, 4, 5, 6, 5, 4, 3, 2, 3};
  int pp_e[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
  int sc_o[7]  = '{3, 6, 9, 6, 3, 0, 3};
  int wr_o[4]  = '{3, 4, 1, 3};
  int sa_o[3]  = '{2, 4, 5};

  initial begin
    rst_n = 1'b0; enable = 1'b1; flip = 1'b0;
    mode = 2'd0; min = 4'd2; max = 4'd6;
    step = 2'd1; load = 1'b0; load_val = '0;
    cyc();
    cyc();
    chk("rst_out", 32'(out), 32'd2);
    chk("rst_dir", 32'(direction), 32'd1);
    chk("rst_bcnt", 32'(bounce_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("pp_out", 32'(out), 32'(pp_o[i]));
      chk("pp_ev", 32'(event_p), 32'(pp_e[i]));
    end
    chk("pp_bcnt", 32'(bounce_cnt), 32'd2);

    restart(0, 9, 3, 0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("clamp_out", 32'(out), 32'(sc_o[i]));
    end

    restart(1, 4, 2, 2);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("wrap_out", 32'(out), 32'(wr_o[i]));
    end
    flip = 1'b1;
    cyc();
    chk("wrap_flip", 32'(out), 32'd1);
    flip = 1'b0;
    cyc();
    chk("wrap_dn", 32'(out), 32'd4);
    chk("wrap_ev", 32'(event_p), 32'd1);

    restart(0, 5, 2, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sat_out", 32'(out), 32'(sa_o[i]));
    end
    chk("sat_done", 32'(done), 32'd1);
    cyc();
    chk("sat_hold", 32'(out), 32'd5);
    flip = 1'b1;
    cyc();
    flip = 1'b0;
    chk("sat_flip", 32'(out), 32'd3);
    chk("sat_undone", 32'(done), 32'd0);

    min = 4'd0; max = 4'd7;
    load = 1'b1; load_val = 4'd15;
    cyc();
    load = 1'b0;
    chk("load_clamp", 32'(out), 32'd7);

    min = 4'd3; max = 4'd3;
    #1;
    chk("err_eq", 32'(err), 32'd1);
    repeat (3) cyc();
    chk("err_freeze", 32'(out), 32'd7);

    restart(0, 1, 1, 0);
    repeat (300) cyc();
    chk("bcnt_sat", 32'(bounce_cnt), 32'(BMAX));
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_bcnt", 32'(bounce_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int lo, hi;
      rst_n  = ($urandom_range(0, 199) != 0);
      enable = ($urandom_range(0, 7) != 0);
      flip   = ($urandom_range(0, 7) == 0);
      load   = ($urandom_range(0, 15) == 0);
      load_val = WIDTH'($urandom);
      step   = STEP_W'($urandom);
      if ($urandom_range(0, 15) == 0)
        mode = 2'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        lo = $urandom_range(0, 14);
        if ($urandom_range(0, 9) == 0)
          hi = $urandom_range(0, lo);
        else
          hi = $urandom_range(lo + 1, 15);
        min = WIDTH'(lo);
        max = WIDTH'(hi);
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
